// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: command codes, FSM states
// and a small command-classification helper.
package usr_pkg;

  // Codes 0-4 keep the encoding of the older 4-bit command register.
  typedef enum logic [3:0] {
    CMD_HOLD  = 4'd0,
    CMD_CLEAR = 4'd1,
    CMD_LOAD  = 4'd2,
    CMD_SHL   = 4'd3,
    CMD_SHR   = 4'd4,
    CMD_ROL   = 4'd5,
    CMD_ROR   = 4'd6,
    CMD_ASR   = 4'd7
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd >= CMD_SHL) && (cmd <= CMD_ASR);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Command/status bundle of the universal shift register; the master issues
// commands, the slave (the register) reports value and handshake status.
interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic             startRegister;
    logic [3:0]       comandRegister;
    logic [WIDTH-1:0] inputRegister;
    logic [AMT_W-1:0] amountRegister;
    logic             serialInRegister;
    logic [WIDTH-1:0] valueRegister;
    logic             serialOutRegister;
    logic             busyRegister;
    logic             doneRegister;

    modport master (
        output startRegister, comandRegister, inputRegister, amountRegister, serialInRegister,
        input  valueRegister, serialOutRegister, busyRegister, doneRegister
    );

    modport slave (
        input  startRegister, comandRegister, inputRegister, amountRegister, serialInRegister,
        output valueRegister, serialOutRegister, busyRegister, doneRegister
    );

endinterface

// File: rtl/universal_shift_register_shift_step.sv
// One combinational shift/rotate step; returns the next value and the bit
// ejected by that step. Non-shift codes pass the value through.
module shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] value,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_value,
    output logic             eject
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        next_value = value;
        eject      = 1'b0;
        case (cmd)
            CMD_SHL: begin
                next_value = {value[WIDTH-2:0], serial_in};
                eject      = value[WIDTH-1];
            end
            CMD_SHR: begin
                next_value = {serial_in, value[WIDTH-1:1]};
                eject      = value[0];
            end
            CMD_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                eject      = value[WIDTH-1];
            end
            CMD_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                eject      = value[0];
            end
            CMD_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                eject      = value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with clear, load and multi-step shift/rotate under a
// start/busy/done handshake; the first shift step lands on the accepting edge.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clockRegister,
    input  logic resetRegister,
    universal_shift_register_if.slave bus
);

    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    state_e           state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [3:0]       cmd_q, cmd_d;

    logic [3:0]       step_cmd;
    logic [WIDTH-1:0] step_value;
    logic             step_eject;

    // The single step unit serves both the accepting edge and the RUN steps.
    assign step_cmd = (state_q == RUN) ? cmd_q : bus.comandRegister;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .cmd        (step_cmd),
        .value      (value_q),
        .serial_in  (bus.serialInRegister),
        .next_value (step_value),
        .eject      (step_eject)
    );

    always_comb begin
        value_d = value_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        state_d = state_q;
        count_d = count_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (bus.startRegister) begin
                    if (bus.comandRegister == CMD_CLEAR) begin
                        value_d = '0;
                        sout_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (bus.comandRegister == CMD_LOAD) begin
                        value_d = bus.inputRegister;
                        done_d  = 1'b1;
                    end else if (is_shift(bus.comandRegister)) begin
                        if (bus.amountRegister == '0) begin
                            done_d = 1'b1;
                        end else begin
                            value_d = step_value;
                            sout_d  = step_eject;
                            if (bus.amountRegister == AMT_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b1;
                                count_d = bus.amountRegister - AMT_W'(1);
                                cmd_d   = bus.comandRegister;
                                state_d = RUN;
                            end
                        end
                    end
                end
            end
            RUN: begin
                value_d = step_value;
                sout_d  = step_eject;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clockRegister) begin
        if (resetRegister) begin
            value_q <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
            count_q <= '0;
            cmd_q   <= CMD_HOLD;
        end else begin
            value_q <= value_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            state_q <= state_d;
            count_q <= count_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus.valueRegister     = value_q;
    assign bus.serialOutRegister = sout_q;
    assign bus.busyRegister      = busy_q;
    assign bus.doneRegister      = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): directed vector
// table, hand-written multi-cycle sequences, and random traffic vs. a model.
module tb_universal_shift_register;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    universal_shift_register_if #(.WIDTH(WIDTH)) bus ();

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clockRegister (clk),
        .resetRegister (rst),
        .bus           (bus)
    );

    typedef struct {
        bit         rst;
        bit         start;
        logic [3:0] cmd;
        logic [7:0] din;
        logic [3:0] amt;
        bit         si;
        logic [7:0] e_val;
        bit         e_sout;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    vec_t vecs[16];

    // Reference model state: plain integers, one accepted command at a time.
    int m_val, m_sout, m_rem, m_cmd, m_busy, m_done;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit r, input bit start, input logic [3:0] cmd,
                         input logic [7:0] din, input logic [3:0] amt, input bit si);
        rst                  = r;
        bus.startRegister    = start;
        bus.comandRegister   = cmd;
        bus.inputRegister    = din;
        bus.amountRegister   = amt;
        bus.serialInRegister = si;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int val, input int sout,
                              input int busy, input int done);
        check({tag, ".value"}, int'(bus.valueRegister), val);
        check({tag, ".sout"},  int'(bus.serialOutRegister), sout);
        check({tag, ".busy"},  int'(bus.busyRegister), busy);
        check({tag, ".done"},  int'(bus.doneRegister), done);
    endtask

    function automatic void m_step(input int c, input int si);
        int v;
        int msb;
        int lsb;
        v   = m_val;
        msb = v / 128;
        lsb = v % 2;
        case (c)
            3: begin m_val = (v * 2) % 256 + si;   m_sout = msb; end
            4: begin m_val = v / 2 + si * 128;     m_sout = lsb; end
            5: begin m_val = (v * 2) % 256 + msb;  m_sout = msb; end
            6: begin m_val = v / 2 + lsb * 128;    m_sout = lsb; end
            7: begin m_val = v / 2 + msb * 128;    m_sout = lsb; end
            default: ;
        endcase
    endfunction

    function automatic void m_edge(input int r, input int start, input int cmd,
                                   input int din, input int amt, input int si);
        m_done = 0;
        if (r != 0) begin
            m_val = 0; m_sout = 0; m_rem = 0; m_busy = 0; m_cmd = 0;
        end else if (m_rem > 0) begin
            m_step(m_cmd, si);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (start != 0) begin
            if (cmd == 1) begin
                m_val = 0; m_sout = 0; m_done = 1;
            end else if (cmd == 2) begin
                m_val = din; m_done = 1;
            end else if (cmd >= 3 && cmd <= 7) begin
                if (amt == 0) begin
                    m_done = 1;
                end else begin
                    m_step(cmd, si);
                    if (amt == 1) begin
                        m_done = 1;
                    end else begin
                        m_rem  = amt - 1;
                        m_busy = 1;
                        m_cmd  = cmd;
                    end
                end
            end
        end
    endfunction

    initial begin
        int done_cnt;
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);

        //            rst start cmd   din    amt   si   val    so busy done
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'h2, 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'h3, 8'h00, 4'd3, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1, 8'h97, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1, 8'h2F, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'h2, 8'h90, 4'd0, 1'b0, 8'h90, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'h7, 8'h00, 4'd2, 1'b1, 8'hC8, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'h0, 8'h55, 4'd3, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'hF, 8'h12, 4'd3, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h1, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'h2, 8'h3C, 4'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'h3, 8'h00, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'h4, 8'h00, 4'd1, 1'b1, 8'h9E, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 4'h5, 8'h00, 4'd1, 1'b0, 8'h3D, 1'b1, 1'b0, 1'b1};

        tick();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].cmd, vecs[i].din, vecs[i].amt, vecs[i].si);
            tick();
            check_outs($sformatf("vec%0d", i), int'(vecs[i].e_val), int'(vecs[i].e_sout),
                       int'(vecs[i].e_busy), int'(vecs[i].e_done));
        end

        // ROR by a full WIDTH brings the value back; done only at the 8th edge.
        drive(1'b0, 1'b1, 4'h2, 8'h81, 4'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'h6, 8'h00, 4'd8, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b0);
        done_cnt = int'(bus.doneRegister);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ror8.busy%0d", i), int'(bus.busyRegister), 1);
            tick();
            done_cnt += int'(bus.doneRegister);
        end
        tick();
        done_cnt += int'(bus.doneRegister);
        check_outs("ror8.final", 8'h81, 1, 0, 1);
        check("ror8.done_count", done_cnt, 1);

        // LOAD issued while busy is dropped; the SHR runs to completion.
        drive(1'b0, 1'b1, 4'h2, 8'hF0, 4'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'h4, 8'h00, 4'd5, 1'b0);
        tick();
        done_cnt = int'(bus.doneRegister);
        drive(1'b0, 1'b1, 4'h2, 8'hFF, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += int'(bus.doneRegister);
        end
        check_outs("shr5.final", 8'h07, 1, 0, 1);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            done_cnt += int'(bus.doneRegister);
        end
        check("shr5.after", int'(bus.valueRegister), 8'h07);
        check("shr5.done_count", done_cnt, 1);

        // Reset mid-RUN, then a zero-length shift.
        drive(1'b0, 1'b1, 4'h2, 8'h55, 4'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'h3, 8'h00, 4'd6, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1);
        tick();
        check_outs("rst_mid", 0, 0, 0, 0);
        drive(1'b0, 1'b1, 4'h3, 8'h00, 4'd0, 1'b1);
        tick();
        check_outs("shl0", 0, 0, 0, 1);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'd0, 1'b1);
        tick();
        check_outs("shl0.after", 0, 0, 0, 0);

        // Random traffic against the model.
        m_edge(1, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 4'h0, 8'h00, 4'd0, 1'b0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            bit         st;
            logic [3:0] c;
            logic [7:0] d;
            logic [3:0] a;
            bit         s;
            r  = ($urandom_range(0, 149) == 0);
            st = ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 7));
            d  = 8'($urandom);
            a  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            s  = 1'($urandom);
            m_edge(int'(r), int'(st), int'(c), int'(d), int'(a), int'(s));
            drive(r, st, c, d, a, s);
            tick();
            check_outs($sformatf("rnd%0d", i), m_val, m_sout, m_busy, m_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor of the 4-bit command register. Holds a WIDTH-bit value and supports clear, parallel load, and multi-step shifts and rotates. Shifts take one bit per clock for a programmable count, under a start/busy/done handshake. It sits in the datapath wherever the design needs a configurable shifter with serial in/out, for example serial links or bit-serial arithmetic.

## Interface
- WIDTH, 8, data width (≥2)
- AMT_W, local, $clog2(WIDTH)+1; width of shift count (0 … 2^AMT_W−1)

- clockRegister  in  1  single clock, rising edge
- resetRegister  in  1  synchronous, active-high reset
- startRegister  in  1  command strobe; sampled only in IDLE
- comandRegister  in  4  command code, sampled with start
- inputRegister  in  WIDTH  parallel load data
- amountRegister  in  AMT_W  shift step count, sampled with start
- serialInRegister  in  1  fill bit for SHL/SHR, sampled live each step
- valueRegister  out  WIDTH  register contents
- serialOutRegister  out  1  last bit shifted/rotated out
- busyRegister  out  1  multi-step shift in progress
- doneRegister  out  1  one-cycle completion pulse

## Operation
- Command codes (0–4 keep predecessor encoding):
  - HOLD=0
  - CLEAR=1
  - LOAD=2
  - SHL=3
  - SHR=4
  - ROL=5
  - ROR=6
  - ASR=7
  - 8–15 reserved
- One step per command:
  - SHL: value<<1, LSB=serialIn.
  - SHR: value>>1, MSB=serialIn.
  - ROL/ROR: wrap the ejected bit.
  - ASR: MSB replicated.
- Ejected bit (MSB for SHL/ROL, LSB otherwise) goes to serialOut.
- FSM states:
  - IDLE: accepts start.
  - RUN: counts remaining steps; command latched at start.
- CLEAR: value=0, serialOut=0.
- LOAD: value=inputRegister; serialOut unchanged.
- Both CLEAR and LOAD pulse done at the sampling edge.
- HOLD or reserved code with start: no state change, no done.
- Shift with amount N:
  - N=0: value unchanged; done pulses at the sampling edge.
  - N≥1: first step is applied at the sampling edge.
  - N=1: done pulses at that edge; busy stays 0.
  - N>1: busy=1 and remaining count=N−1; enter RUN.
  - RUN: one step per edge, count decrements.
  - Last step: busy→0, done→1, return to IDLE.
- N ≥ WIDTH is legal; all N steps are performed.
- start while busy is ignored (including CLEAR/LOAD); no queuing.
- start low: register holds.
- Reset, including mid-shift, at the next edge:
  - valueRegister=0, serialOutRegister=0, busyRegister=0, doneRegister=0, FSM=IDLE, count=0.
  - Any in-flight shift is discarded.

## Timing
- Every output is registered; no combinational input→output path.
- Latency:
  - CLEAR/LOAD: 1 edge.
  - Shift by N≥1: N edges; the final value and the done pulse appear together.
- done is high for exactly one cycle per accepted command.
- start in the cycle after done is accepted, giving back-to-back throughput.

## Structure
- Package usr_pkg holds:
  - command code constants (4-bit enum);
  - FSM state enum {IDLE, RUN}.
- Sub-module shift_step (combinational): inputs command, value, serialIn; outputs next value and ejected bit. It is shared by the first-step path and the RUN path.
- The top level holds the FSM, the step counter and the output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset, then start LOAD 0xA5:
  - After reset: outputs all 0.
  - Next edge: value=0xA5, done=1 for one cycle, busy=0.
- From 0xA5, SHL N=3 with serialIn=1:
  - Value sequence: 0x4B, 0x97, 0x2F on consecutive edges.
  - busy high for 2 cycles; done with 0x2F; serialOut=1.
- Rotate/arithmetic shifts:
  - ROR N=8 on 0x81: value=0x81 after 8 edges.
  - ASR N=2 on 0x90: 0xC8 then 0xE4; serialOut=0.
- During a SHR N=5, start LOAD 0xFF while busy: load ignored, shift completes normally, exactly one done.
- Timing and reset:
  - resetRegister mid-RUN: next edge value=0, busy=0, done=0.
  - Then SHL N=0: value unchanged, done pulses at the next edge.
- Start with code 0xF or HOLD: value, serialOut and busy unchanged; done stays 0.
